// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock with the carry kept in a flop,
// valid/ready handshakes on the operand and result sides.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             ci,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             ovf,
  output logic             busy
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam logic [CW-1:0] STEP_LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic             carry_reg;
  logic [CW-1:0]    step_reg;
  logic [WIDTH-1:0] out_reg;
  logic             co_reg;
  logic             ovf_reg;

  logic [DIGIT:0]   dsum;
  logic             msb_cin;
  logic [WIDTH-1:0] opa_shift;
  logic [WIDTH-1:0] opb_shift;
  logic [WIDTH-1:0] res_full;

  assign dsum = {1'b0, opa_reg[DIGIT-1:0]} + {1'b0, opb_reg[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_reg};
  // Carry into the digit MSB recovered from the sum bit instead of a second adder.
  assign msb_cin = dsum[DIGIT-1] ^ opa_reg[DIGIT-1] ^ opb_reg[DIGIT-1];

  if (DIGIT == WIDTH) begin : g_single
    assign opa_shift = '0;
    assign opb_shift = '0;
    assign res_full  = dsum[DIGIT-1:0];
  end else begin : g_multi
    // Only the upper WIDTH-DIGIT bits of partial result are ever read back.
    logic [WIDTH-DIGIT-1:0] res_reg;

    assign opa_shift = {{DIGIT{1'b0}}, opa_reg[WIDTH-1:DIGIT]};
    assign opb_shift = {{DIGIT{1'b0}}, opb_reg[WIDTH-1:DIGIT]};
    assign res_full  = {dsum[DIGIT-1:0], res_reg};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_reg <= '0;
      end else if (state_reg == RUN) begin
        res_reg <= res_full[WIDTH-1:DIGIT];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      opa_reg   <= '0;
      opb_reg   <= '0;
      carry_reg <= 1'b0;
      step_reg  <= '0;
      out_reg   <= '0;
      co_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            opa_reg   <= A;
            opb_reg   <= sub ? ~B : B;
            carry_reg <= sub ? ~ci : ci;
            step_reg  <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          opa_reg   <= opa_shift;
          opb_reg   <= opb_shift;
          carry_reg <= dsum[DIGIT];
          step_reg  <= step_reg + CW'(1);
          if (step_reg == STEP_LAST) begin
            out_reg   <= res_full;
            co_reg    <= dsum[DIGIT];
            ovf_reg   <= msb_cin ^ dsum[DIGIT];
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out       = out_reg;
  assign co        = co_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: hand-computed vectors on WIDTH=8/DIGIT=2 plus
// random sweeps on three other geometries against a whole-word arithmetic model.
module tb_serial_addsub;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  // Main instance, WIDTH=8 DIGIT=2
  logic       in_valid0, in_ready0, sub0, ci0, out_valid0, out_ready0, co0, ovf0, busy0;
  logic [7:0] a0, b0, out0;

  // Sweep instances share one stimulus set
  logic        sw_valid, sw_sub, sw_ci;
  logic [11:0] sw_a, sw_b;
  logic        ir1, ov1, co1, vf1, bz1;
  logic        ir2, ov2, co2, vf2, bz2;
  logic        ir3, ov3, co3, vf3, bz3;
  logic [7:0]  out1, out2;
  logic [11:0] out3;

  serial_addsub #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .sub(sub0), .ci(ci0), .A(a0), .B(b0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out(out0), .co(co0), .ovf(ovf0), .busy(busy0));

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir1),
    .sub(sw_sub), .ci(sw_ci), .A(sw_a[7:0]), .B(sw_b[7:0]), .out_valid(ov1),
    .out_ready(1'b1), .out(out1), .co(co1), .ovf(vf1), .busy(bz1));

  serial_addsub #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir2),
    .sub(sw_sub), .ci(sw_ci), .A(sw_a[7:0]), .B(sw_b[7:0]), .out_valid(ov2),
    .out_ready(1'b1), .out(out2), .co(co2), .ovf(vf2), .busy(bz2));

  serial_addsub #(.WIDTH(12), .DIGIT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir3),
    .sub(sw_sub), .ci(sw_ci), .A(sw_a), .B(sw_b), .out_valid(ov3),
    .out_ready(1'b1), .out(out3), .co(co3), .ovf(vf3), .busy(bz3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c);
    a0 = a; b0 = b; sub0 = s; ci0 = c;
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
  endtask

  // Cycles counted from the accept edge; in_ready must stay low while waiting.
  task automatic await_done(input int exp_lat, input string tag);
    int lat = 0;
    while (out_valid0 !== 1'b1 && lat < 40) begin
      check({tag, "_in_ready_busy"}, 32'(in_ready0), 32'd0);
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_res(input string tag, input logic [7:0] o, input logic c, input logic v);
    check({tag, "_out"}, 32'(out0), 32'(o));
    check({tag, "_co"},  32'(co0),  32'(c));
    check({tag, "_ovf"}, 32'(ovf0), 32'(v));
  endtask

  task automatic handshake(input string tag);
    out_ready0 = 1'b1;
    tick();
    out_ready0 = 1'b0;
    check({tag, "_hs_valid"}, 32'(out_valid0), 32'd0);
    check({tag, "_hs_ready"}, 32'(in_ready0), 32'd1);
  endtask

  // Whole-word reference: returns {ovf, co, out[11:0]}
  function automatic logic [13:0] model(input int w, input logic [11:0] a, input logic [11:0] b,
                                        input logic s, input logic c);
    int m, lm, aa, bb, cc, full, cin, cout;
    m    = (1 << w) - 1;
    lm   = m >> 1;
    aa   = int'(a) & m;
    bb   = (s ? ~int'(b) : int'(b)) & m;
    cc   = s ? int'(!c) : int'(c);
    full = aa + bb + cc;
    cout = (full >> w) & 1;
    cin  = (((aa & lm) + (bb & lm) + cc) >> (w - 1)) & 1;
    return {cin[0] ^ cout[0], cout[0], 12'(full & m)};
  endfunction

  initial begin
    logic [13:0] exp1, exp2, exp3;
    int lat1, lat2, lat3;

    rst_n = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b0; sub0 = 1'b0; ci0 = 1'b0; a0 = '0; b0 = '0;
    sw_valid = 1'b0; sw_sub = 1'b0; sw_ci = 1'b0; sw_a = '0; sw_b = '0;

    #12;
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_in_ready",  32'(in_ready0),  32'd1);
    check("rst_busy",      32'(busy0),      32'd0);
    check_res("rst", 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Signed overflow on add, then hold result in IDLE after handshake
    accept(8'h35, 8'h4A, 1'b0, 1'b1);
    await_done(4, "add_ovf");
    check("add_ovf_busy", 32'(busy0), 32'd1);
    check_res("add_ovf", 8'h80, 1'b0, 1'b1);
    handshake("add_ovf");
    check_res("add_ovf_idle_hold", 8'h80, 1'b0, 1'b1);

    accept(8'h10, 8'h20, 1'b1, 1'b0);
    await_done(4, "sub_borrow");
    check_res("sub_borrow", 8'hF0, 1'b0, 1'b0);
    handshake("sub_borrow");

    accept(8'h80, 8'h01, 1'b1, 1'b0);
    await_done(4, "sub_ovf");
    check_res("sub_ovf", 8'h7F, 1'b1, 1'b1);
    handshake("sub_ovf");

    accept(8'hFF, 8'h01, 1'b0, 1'b0);
    await_done(4, "wrap0");
    check_res("wrap0", 8'h00, 1'b1, 1'b0);
    handshake("wrap0");

    accept(8'hFF, 8'hFF, 1'b0, 1'b1);
    await_done(4, "wrap1");
    check_res("wrap1", 8'hFF, 1'b1, 1'b0);
    handshake("wrap1");

    // Backpressure: operand churn and in_valid pulses while running and while held
    accept(8'h12, 8'h34, 1'b0, 1'b0);
    tick();
    a0 = 8'hFF; b0 = 8'hFF; sub0 = 1'b1; in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0; a0 = 8'h77;
    await_done(2, "bp");
    for (int i = 0; i < 3; i++) begin
      in_valid0 = 1'b1;
      a0 = 8'($urandom); b0 = 8'($urandom);
      check("bp_hold_valid", 32'(out_valid0), 32'd1);
      check("bp_hold_ready", 32'(in_ready0), 32'd0);
      check_res("bp_hold", 8'h46, 1'b0, 1'b0);
      tick();
    end
    in_valid0 = 1'b0;
    handshake("bp");
    check_res("bp_after", 8'h46, 1'b0, 1'b0);

    // Asynchronous reset two cycles into RUN
    accept(8'h55, 8'h11, 1'b0, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid0), 32'd0);
    check("arst_busy",      32'(busy0),      32'd0);
    check("arst_in_ready",  32'(in_ready0),  32'd1);
    check_res("arst", 8'h00, 1'b0, 1'b0);
    #10 rst_n = 1'b1;
    tick();
    accept(8'h01, 8'h02, 1'b0, 1'b0);
    await_done(4, "post_rst");
    check_res("post_rst", 8'h03, 1'b0, 1'b0);
    handshake("post_rst");

    // Random sweep across the bit-serial, single-step and 12/3 geometries
    for (int n = 0; n < 1000; n++) begin
      sw_a   = 12'($urandom_range(0, 4095));
      sw_b   = 12'($urandom_range(0, 4095));
      sw_sub = 1'($urandom);
      sw_ci  = 1'($urandom);
      exp1 = model(8, sw_a, sw_b, sw_sub, sw_ci);
      exp2 = exp1;
      exp3 = model(12, sw_a, sw_b, sw_sub, sw_ci);
      lat1 = 0; lat2 = 0; lat3 = 0;
      sw_valid = 1'b1;
      tick();
      sw_valid = 1'b0;
      for (int t = 1; t <= 10; t++) begin
        tick();
        if (ov1 === 1'b1 && lat1 == 0) begin
          lat1 = t;
          check("sweep_w8d1", {18'd0, vf1, co1, 4'd0, out1}, {18'd0, exp1});
        end
        if (ov2 === 1'b1 && lat2 == 0) begin
          lat2 = t;
          check("sweep_w8d8", {18'd0, vf2, co2, 4'd0, out2}, {18'd0, exp2});
        end
        if (ov3 === 1'b1 && lat3 == 0) begin
          lat3 = t;
          check("sweep_w12d3", {18'd0, vf3, co3, out3}, {18'd0, exp3});
        end
      end
      check("sweep_w8d1_latency",  32'(lat1), 32'd8);
      check("sweep_w8d8_latency",  32'(lat2), 32'd1);
      check("sweep_w12d3_latency", 32'(lat3), 32'd4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
